lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//   Load/store unit between core MEM stage and word-addressed data memory (1-cycle read latency).
//   Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses.
//   Sub-word stores use read-modify-write; loads are sign/zero-extended.
//   Flags misaligned, illegal and out-of-range requests without touching memory.
// PARAMETERS
//   ADDRW  8  byte-address width of data memory; addr[31:ADDRW] must be 0
// PORTS
//   clk            in   1   clock
//   rst            in   1   reset, synchronous, active-high
//   req_valid      in   1   request present
//   req_ready      out  1   unit can accept (IDLE and !rst)
//   req_we         in   1   1=store, 0=load
//   req_funct3     in   3   RV32I funct3 (size/sign)
//   req_addr       in   32  byte address
//   req_wdata      in   32  store data, LSB-aligned
//   resp_valid     out  1   1-cycle pulse: request complete
//   resp_rdata     out  32  extended load data (0 for stores/errors)
//   resp_err       out  1   misaligned / illegal funct3 / out of range
//   mem_we         out  1   memory write enable
//   mem_addr       out  32  word-aligned byte address {addr[31:2],2'b00}
//   mem_din        out  32  memory write data
//   mem_dout       in   32  memory read data, valid 1 cycle after mem_addr
// BEHAVIOUR
//   Accept: req_valid && req_ready at edge T latches all req_* fields; req_ready=0 until back in IDLE.
//   FSM states: IDLE, READ, DATA, WRITE, RESP.
//     IDLE  -> RESP  on err
//     IDLE  -> WRITE on SW
//     IDLE  -> READ  on any load, SB or SH
//     READ: mem_addr driven, mem_we=0 -> DATA
//     DATA: mem_dout sampled. Load -> RESP with extracted data. SB/SH -> WRITE with merged word.
//     WRITE: mem_we=1, mem_addr, mem_din driven for exactly 1 cycle -> RESP.
//     RESP: resp_valid=1 for 1 cycle -> IDLE. No backpressure; consumer must take it.
//   Latency, cycles after accept edge to resp_valid high:
//     err 1; SW 2; loads 3; SB/SH 4.
//   funct3 decode: 000 B, 001 H, 010 W, 100 BU, 101 HU.
//     011/110/111 -> err. BU/HU with req_we=1 -> err.
//   Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
//   Out of range: addr[31:ADDRW]!=0.
//   Lanes (little-endian): byte lane = addr[1:0]; half lane = addr[1].
//     Load: selected lane sign-extended (B,H) or zero-extended (BU,HU); W returned whole.
//     Store merge: replace selected lane of mem_dout with req_wdata[7:0] or [15:0]; other bytes kept.
//   Outputs outside active states:
//     mem_we=0, mem_addr=0, mem_din=0, resp_valid=0.
//     resp_rdata and resp_err hold last value until the next RESP.
//   Reset (any cycle, incl. mid-operation):
//     Next state IDLE; all outputs 0; req_ready low during rst, high the cycle after.
//     An in-flight op is dropped, no resp_valid.
//     A WRITE-state cycle coinciding with rst drives mem_we=0.
//   Simultaneous req_valid and rst: request ignored.
//   Back-to-back: a new request may be accepted in the cycle after RESP (IDLE).
// TESTING
//   LW addr 0x10, mem[4]=0xDEADBEEF -> resp_valid at T+3, rdata 0xDEADBEEF, err 0, no mem_we.
//   LB 0x13 / LBU 0x13, mem[4]=0x80FF1234 -> rdata 0xFFFFFF80 / 0x00000080.
//   SB 0x11 data 0xAB, mem[4]=0x11223344 -> one mem_we pulse at T+3, din 0x1122AB44, resp T+4.
//   SW 0x20 then LH 0x22 -> mem[8]=0xCAFE5678, LH rdata 0xFFFFCAFE.
//   LH 0x11 / SW 0x22 / funct3 011 / LW 0x100 -> err=1 at T+1, mem_we never asserted, rdata 0.
//   rst asserted in DATA of SH -> no mem_we, no resp_valid, req_ready=1 after rst.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns RV32I byte/half/word accesses into word-wide memory traffic,
// using read-modify-write for sub-word stores and flagging bad requests without a memory access.
module lsu_ctrl #(
  parameter int unsigned ADDRW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_din,
  input  logic [31:0] i_mem_dout
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StData,
    StWrite,
    StResp
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_f3_ok;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_req_err;
  logic        w_is_sw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign o_req_ready = (r_state == StIdle) && !rst;
  assign w_accept    = i_req_valid && o_req_ready;

  always_comb begin
    w_f3_ok = 1'b0;
    case (i_req_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !i_req_we;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  assign w_misaligned   = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                          ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
  assign w_out_of_range = (i_req_addr >> ADDRW) != 32'd0;
  assign w_req_err      = !w_f3_ok || w_misaligned || w_out_of_range;
  assign w_is_sw        = i_req_we && (i_req_funct3 == 3'b010);

  // Lane extraction and merge operate on the word returned for the latched address.
  assign w_byte = i_mem_dout[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = i_mem_dout[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = i_mem_dout;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = i_mem_dout;
    endcase
  end

  always_comb begin
    w_merged = i_mem_dout;
    if (r_funct3[1:0] == 2'b00) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_req_err)    w_state_d = StResp;
          else if (w_is_sw) w_state_d = StWrite;
          else              w_state_d = StRead;
        end
      end
      StRead:  w_state_d = StData;
      StData:  w_state_d = r_we ? StWrite : StResp;
      StWrite: w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (rst) w_state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_we     <= i_req_we;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        if (w_req_err) begin
          r_rdata <= 32'd0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == StData) begin
        if (r_we) begin
          r_wdata <= w_merged;
        end else begin
          r_rdata <= w_load;
          r_err   <= 1'b0;
        end
      end
      if (r_state == StWrite) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  // Every output is forced low while rst is high, including a WRITE cycle caught by reset.
  always_comb begin
    o_resp_valid = (r_state == StResp) && !rst;
    o_mem_we     = (r_state == StWrite) && !rst;
    o_mem_addr   = 32'd0;
    o_mem_din    = 32'd0;
    o_resp_rdata = rst ? 32'd0 : r_rdata;
    o_resp_err   = rst ? 1'b0 : r_err;
    if (!rst && ((r_state == StRead) || (r_state == StData) || (r_state == StWrite))) begin
      o_mem_addr = {r_addr[31:2], 2'b00};
    end
    if (o_mem_we) o_mem_din = r_wdata;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table against a behavioural 1-cycle-latency memory,
// plus hand sequences for reset in mid-operation and reset coinciding with a request.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_din;
  logic [31:0] i_mem_dout;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDRW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_din    (o_mem_din),
    .i_mem_dout   (i_mem_dout)
  );

  // Memory model, 64 words; the bench preloads words through the same write port.
  logic [31:0] mem [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (o_mem_we) mem[o_mem_addr[7:2]] <= o_mem_din;
    i_mem_dout <= mem[o_mem_addr[7:2]];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] pre_val;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
    logic [31:0] exp_word;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int wes,
                         output logic [31:0] rdata, output logic err, output logic rdy);
    @(negedge clk);
    rdy          = o_req_ready;
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    @(negedge clk);
    i_req_valid = 1'b0;
    lat = 1;
    wes = 0;
    while (!o_resp_valid && lat < 12) begin
      if (o_mem_we) wes++;
      @(negedge clk);
      lat++;
    end
    if (o_mem_we) wes++;
    rdata = o_resp_rdata;
    err   = o_resp_err;
  endtask

  int          lat, wes, cnt_we, cnt_resp;
  logic [31:0] rdata;
  logic        err, rdy;

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF,
                 32'hDEADBEEF, 1'b0, 3, 0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'h80FF1234,
                 32'hFFFFFF80, 1'b0, 3, 0, 32'h80FF1234};
    vecs[2]  = '{1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 32'h80FF1234,
                 32'h00000080, 1'b0, 3, 0, 32'h80FF1234};
    vecs[3]  = '{1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'h80FF1234,
                 32'hFFFF80FF, 1'b0, 3, 0, 32'h80FF1234};
    vecs[4]  = '{1'b0, 3'b101, 32'h10, 32'h0, 1'b1, 32'h80FF1234,
                 32'h00001234, 1'b0, 3, 0, 32'h80FF1234};
    vecs[5]  = '{1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 32'h80FF1234,
                 32'h00000034, 1'b0, 3, 0, 32'h80FF1234};
    vecs[6]  = '{1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h55555555,
                 32'h0, 1'b1, 1, 0, 32'h55555555};
    vecs[7]  = '{1'b1, 3'b000, 32'h11, 32'hAB, 1'b1, 32'h11223344,
                 32'h0, 1'b0, 4, 1, 32'h1122AB44};
    vecs[8]  = '{1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 32'h55555555,
                 32'h0, 1'b1, 1, 0, 32'h55555555};
    vecs[9]  = '{1'b1, 3'b001, 32'h16, 32'h0000BEEF, 1'b1, 32'h11223344,
                 32'h0, 1'b0, 4, 1, 32'hBEEF3344};
    vecs[10] = '{1'b1, 3'b010, 32'h22, 32'h01020304, 1'b1, 32'hAAAAAAAA,
                 32'h0, 1'b1, 1, 0, 32'hAAAAAAAA};
    vecs[11] = '{1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h00000005,
                 32'h0, 1'b1, 1, 0, 32'h00000005};
    vecs[12] = '{1'b1, 3'b100, 32'h14, 32'hFF, 1'b1, 32'h00000066,
                 32'h0, 1'b1, 1, 0, 32'h00000066};
    vecs[13] = '{1'b0, 3'b010, 32'h31, 32'h0, 1'b1, 32'h00000077,
                 32'h0, 1'b1, 1, 0, 32'h00000077};
    vecs[14] = '{1'b1, 3'b000, 32'h1F, 32'h12345699, 1'b1, 32'h0,
                 32'h0, 1'b0, 4, 1, 32'h99000000};
    vecs[15] = '{1'b1, 3'b010, 32'h20, 32'hCAFE5678, 1'b1, 32'h0,
                 32'h0, 1'b0, 2, 1, 32'hCAFE5678};
    // Chained straight after the SW, no preload: reads back what the store wrote.
    vecs[16] = '{1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'h0,
                 32'hFFFFCAFE, 1'b0, 3, 0, 32'hCAFE5678};

    rst          = 1'b1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_funct3 = 3'd0;
    i_req_addr   = 32'd0;
    i_req_wdata  = 32'd0;
    pre_we       = 1'b0;
    pre_idx      = 6'd0;
    pre_val      = 32'd0;

    repeat (3) @(negedge clk);
    check("rst ready", {31'd0, o_req_ready}, 32'd0);
    check("rst resp_valid", {31'd0, o_resp_valid}, 32'd0);
    check("rst mem_we", {31'd0, o_mem_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst ready", {31'd0, o_req_ready}, 32'd1);
    check("post-rst rdata", o_resp_rdata, 32'd0);
    check("post-rst err", {31'd0, o_resp_err}, 32'd0);
    check("post-rst mem_addr", o_mem_addr, 32'd0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre) preload(vecs[i].addr[7:2], vecs[i].pre_val);
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, wes, rdata, err, rdy);
      check($sformatf("v%0d ready", i), {31'd0, rdy}, 32'd1);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d mem_we pulses", i), 32'(wes), 32'(vecs[i].exp_wes));
      check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d mem word", i), mem[vecs[i].addr[7:2]], vecs[i].exp_word);
    end

    // Idle after the last load: response data holds, memory outputs are zero.
    repeat (3) @(negedge clk);
    check("hold rdata", o_resp_rdata, 32'hFFFFCAFE);
    check("idle mem_addr", o_mem_addr, 32'd0);
    check("idle mem_din", o_mem_din, 32'd0);

    // Reset while an SH sits in DATA: op dropped, memory untouched.
    preload(6'd5, 32'h11223344);
    @(negedge clk);
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = 3'b001;
    i_req_addr   = 32'h14;
    i_req_wdata  = 32'h00007777;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    check("sh data mem_addr", o_mem_addr, 32'h14);
    rst = 1'b1;
    #1;
    check("sh rst ready", {31'd0, o_req_ready}, 32'd0);
    check("sh rst mem_addr", o_mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("sh after-rst ready", {31'd0, o_req_ready}, 32'd1);
    cnt_we   = 0;
    cnt_resp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_mem_we) cnt_we++;
      if (o_resp_valid) cnt_resp++;
    end
    check("sh rst mem_we count", 32'(cnt_we), 32'd0);
    check("sh rst resp count", 32'(cnt_resp), 32'd0);
    check("sh rst mem word", mem[5], 32'h11223344);

    // Reset landing on the WRITE cycle of an SW must suppress the write.
    preload(6'd9, 32'h0);
    @(negedge clk);
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = 3'b010;
    i_req_addr   = 32'h24;
    i_req_wdata  = 32'h12345678;
    @(negedge clk);
    i_req_valid = 1'b0;
    check("sw write mem_we", {31'd0, o_mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("sw rst mem_we", {31'd0, o_mem_we}, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    cnt_resp = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (o_resp_valid) cnt_resp++;
    end
    check("sw rst resp count", 32'(cnt_resp), 32'd0);
    check("sw rst mem word", mem[9], 32'd0);

    // Request presented together with reset is ignored.
    @(negedge clk);
    rst          = 1'b1;
    i_req_valid  = 1'b1;
    i_req_we     = 1'b0;
    i_req_funct3 = 3'b010;
    i_req_addr   = 32'h10;
    @(negedge clk);
    rst         = 1'b0;
    i_req_valid = 1'b0;
    #1;
    check("rst+req ready", {31'd0, o_req_ready}, 32'd1);
    cnt_resp = 0;
    cnt_we   = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (o_resp_valid) cnt_resp++;
      if (o_mem_addr != 32'd0) cnt_we++;
    end
    check("rst+req resp count", 32'(cnt_resp), 32'd0);
    check("rst+req mem access", 32'(cnt_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
